exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 WB  in  2  WB control from the ID/EX register: [0] regwrite, [1] memToReg.
REQ-005 M  in  3  memory control: [0] memread, [1] memwrite, [2] iord.
REQ-006 EX  in  10  execute control: [5:0] aluctrl, [7:6] aluSrc, [8] noDest, [9] regDst.
REQ-007 regRs, regRt, imm_value, PC  in  32 each  operands from the ID/EX register.
REQ-008 addrRt, addrRd  in  5 each  destination candidates.
REQ-009 flush  in  1  replaces the current instruction with a bubble.
REQ-010 WBOut  out  2  registered EX/MEM copy of WB.
REQ-011 MOut  out  3  registered EX/MEM copy of M.
REQ-012 aluResultOut  out  32  registered ALU result.
REQ-013 storeDataOut  out  32  registered regRt.
REQ-014 destAddrOut  out  5  registered destination register.
REQ-015 overflowOut  out  1  registered signed-overflow flag.
REQ-016 stall  out  1  combinational; when high, upstream holds ID/EX and PC.

Function
REQ-017 Operand A SHALL be regRs.
- Operand B SHALL be selected by aluSrc: 00 regRt, 01 imm_value, 1x treated as 00.
REQ-018 aluctrl SHALL encode the following operations:
- 20 ADD, 21 ADDU, 22 SUB, 23 SUBU.
- 24 AND, 25 OR, 26 XOR, 27 NOR.
- 2A SLT (signed), 2B SLTU.
- 00 SLL, 02 SRL, 03 SRA: operand B shifted by imm_value[10:6].
- 0F LUI: {B[15:0],16'h0}.
- 10 MFHI, 12 MFLO.
- 18 MULT, 19 MULTU, 1A DIV, 1B DIVU.
- All other codes: result 0.
REQ-019 destAddrOut SHALL be 0 if noDest=1, else addrRd if regDst=1, else addrRt.
REQ-020 Single-cycle operations SHALL register their result and all control fields at the next rising edge (latency 1, stall=0).
REQ-021 ADD and SUB signed overflow SHALL set overflowOut=1 and force WBOut=00 for that instruction; the unsigned forms never set overflowOut.
REQ-022 A multiply/divide unit SHALL use the states IDLE and BUSY, with a 5-bit counter cnt.
REQ-023 IDLE with a MULT/MULTU/DIV/DIVU opcode and flush=0:
- assert stall;
- latch both operands;
- go to BUSY with cnt=0.
REQ-024 BUSY SHALL perform one iteration per cycle:
- shift-add for multiply; restoring division for divide;
- signed forms operate on magnitudes and fix signs at completion.
REQ-025 stall SHALL be 1 in BUSY for cnt 0..30 and 0 at cnt=31.
- HI and LO are written at the edge ending cnt=31.
- The state then returns to IDLE.
- Total stall length is 32 cycles.
REQ-026 A multiply/divide opcode presented while BUSY SHALL NOT restart the unit.
REQ-027 Multiply results: HI:LO = 64-bit product (signed for MULT).
REQ-028 Divide results: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-029 Divide by zero SHALL give LO=32'hFFFFFFFF and HI=dividend, in the same 32 cycles.
REQ-030 While stall=1, the EX/MEM outputs SHALL load a bubble.
- In the release cycle (cnt=31), the instruction's own control fields load normally.
REQ-031 MFHI/MFLO SHALL read the HI/LO registers, so an MFHI/MFLO immediately after release sees the new values.
REQ-032 flush=1 in IDLE SHALL load a bubble and SHALL NOT start the unit.
REQ-033 flush SHALL be ignored while BUSY.
REQ-034 A bubble SHALL mean WBOut=00, MOut=000 and overflowOut=0; the data outputs are don't-care but SHALL be driven to 0.

Reset
REQ-035 While reset=0, the following SHALL apply at any time, including mid-operation:
- all registered outputs, HI, LO and cnt are 0;
- state is IDLE;
- stall is 0.
REQ-036 After reset deasserts, the first edge SHALL process the presented instruction normally.

Verification
REQ-037 ADD, regRs=5, regRt=7, regDst=1, addrRd=3 -> next edge: aluResultOut=12, destAddrOut=3, WBOut=WB, overflowOut=0.
REQ-038 ADD, 32'h7FFFFFFF + 1 -> aluResultOut=32'h80000000, overflowOut=1, WBOut=00.
REQ-039 MULT, -3 * 5 -> stall high for exactly 32 cycles with bubbles out; then MFLO returns 32'hFFFFFFF1 and MFHI returns 32'hFFFFFFFF.
REQ-040 Divide cases:
- DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=-3, HI=-1.
- DIVU 9/0 -> LO=32'hFFFFFFFF, HI=9.
REQ-041 Reset during DIV at cnt=10 -> stall=0 immediately, outputs 0; after release MFLO returns 0.
REQ-042 flush with a MULT in IDLE -> no stall, bubble out, HI/LO unchanged.

Source files
------------

// File: rtl/exec_stage_if.sv
// exec_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage
// master drives the i_* fields and samples the o_* fields; slave is the stage itself.
// i_wb/i_m/i_ex: control, i_reg_rs/i_reg_rt/i_imm/i_pc: operands, i_addr_rt/i_addr_rd: destinations,
// i_flush: bubble request, o_*: registered EX/MEM fields, o_stall: combinational hold request.
interface exec_stage_if;
  logic [1:0] i_wb;
  logic [2:0] i_m;
  logic [9:0] i_ex;
  logic [31:0] i_reg_rs, i_reg_rt, i_imm, i_pc;
  logic [4:0] i_addr_rt, i_addr_rd;
  logic i_flush;
  logic [1:0] o_wb;
  logic [2:0] o_m;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0] o_dest_addr;
  logic o_overflow, o_stall;
  modport master (
    output i_wb, i_m, i_ex, i_reg_rs, i_reg_rt, i_imm, i_pc, i_addr_rt, i_addr_rd, i_flush,
    input o_wb, o_m, o_alu_result, o_store_data, o_dest_addr, o_overflow, o_stall
  );
  modport slave (
    input i_wb, i_m, i_ex, i_reg_rs, i_reg_rt, i_imm, i_pc, i_addr_rt, i_addr_rd, i_flush,
    output o_wb, o_m, o_alu_result, o_store_data, o_dest_addr, o_overflow, o_stall
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: pipeline execute stage with single-cycle ALU and a 32-cycle iterative mul/div unit
// clk: rising-edge clock, rst_n: asynchronous active-low reset, bus: exec_stage_if slave port.
module exec_stage (
  input logic clk,
  input logic rst_n,
  exec_stage_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_next;
  logic [4:0] r_cnt, r_dest;
  logic [31:0] r_hi, r_lo, r_b, r_alu, r_store;
  logic [63:0] r_acc, w_acc_step, w_prod;
  logic [1:0] r_wb;
  logic [2:0] r_m;
  logic r_div, r_neg_q, r_neg_r, r_dz, r_ovf;
  logic [5:0] w_op;
  logic [31:0] w_a, w_b, w_res, w_am, w_bm, w_q, w_r;
  logic [4:0] w_sh;
  logic [32:0] w_madd, w_trial;
  logic [33:0] w_diff;
  logic w_ovf, w_md, w_start, w_done, w_stall, w_bubble, w_unused;
  assign w_op = bus.i_ex[5:0];
  assign w_a = bus.i_reg_rs;
  assign w_b = bus.i_ex[7:6] == 2'b01 ? bus.i_imm : bus.i_reg_rt;
  assign w_sh = bus.i_imm[10:6];
  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B; bit0 marks the unsigned form, bit1 divide
  assign w_md = w_op[5:2] == 4'b0110;
  assign w_unused = ^{bus.i_pc, w_diff[32]};
  always_comb begin
    w_res = 32'd0;
    w_ovf = 1'b0;
    case (w_op)
      6'h20: begin
        w_res = w_a + w_b;
        w_ovf = (w_a[31] == w_b[31]) && (w_res[31] != w_a[31]);
      end
      6'h21: w_res = w_a + w_b;
      6'h22: begin
        w_res = w_a - w_b;
        w_ovf = (w_a[31] != w_b[31]) && (w_res[31] != w_a[31]);
      end
      6'h23: w_res = w_a - w_b;
      6'h24: w_res = w_a & w_b;
      6'h25: w_res = w_a | w_b;
      6'h26: w_res = w_a ^ w_b;
      6'h27: w_res = ~(w_a | w_b);
      6'h2A: w_res = {31'd0, $signed(w_a) < $signed(w_b)};
      6'h2B: w_res = {31'd0, w_a < w_b};
      6'h00: w_res = w_b << w_sh;
      6'h02: w_res = w_b >> w_sh;
      6'h03: w_res = $signed(w_b) >>> w_sh;
      6'h0F: w_res = {w_b[15:0], 16'h0};
      6'h10: w_res = r_hi;
      6'h12: w_res = r_lo;
      default: w_res = 32'd0;
    endcase
  end
  // signed forms run on magnitudes; signs are restored when the result is written
  assign w_am = (!w_op[0] && w_a[31]) ? -w_a : w_a;
  assign w_bm = (!w_op[0] && w_b[31]) ? -w_b : w_b;
  // multiply: r_acc = {partial, multiplier}, add-then-shift-right with carry
  assign w_madd = r_acc[0] ? {1'b0, r_acc[63:32]} + {1'b0, r_b} : {1'b0, r_acc[63:32]};
  // divide: r_acc = {remainder, quotient}, shift left and trial-subtract (restoring)
  assign w_trial = r_acc[63:31];
  assign w_diff = {1'b0, w_trial} - {2'b0, r_b};
  assign w_acc_step = !r_div ? {w_madd, r_acc[31:1]}
                    : w_diff[33] ? {w_trial[31:0], r_acc[30:0], 1'b0}
                    : {w_diff[31:0], r_acc[30:0], 1'b1};
  assign w_q = w_acc_step[31:0];
  assign w_r = w_acc_step[63:32];
  assign w_prod = r_neg_q ? -w_acc_step : w_acc_step;
  assign w_start = r_state == IDLE && w_md && !bus.i_flush;
  assign w_done = r_state == BUSY && r_cnt == 5'd31;
  always_comb begin
    w_state_next = r_state;
    w_stall = 1'b0;
    w_bubble = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = w_start ? BUSY : IDLE;
        w_stall = w_start;
        w_bubble = w_start || bus.i_flush;
      end
      BUSY: begin
        w_state_next = w_done ? IDLE : BUSY;
        w_stall = !w_done;
        w_bubble = !w_done;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= 5'd0;
      r_hi <= 32'd0;
      r_lo <= 32'd0;
      r_acc <= 64'd0;
      r_b <= 32'd0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_wb <= 2'd0;
      r_m <= 3'd0;
      r_alu <= 32'd0;
      r_store <= 32'd0;
      r_dest <= 5'd0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt <= r_state == BUSY ? r_cnt + 5'd1 : 5'd0;
      if (w_start) begin
        r_div <= w_op[1];
        r_neg_q <= !w_op[0] && (w_a[31] ^ w_b[31]);
        r_neg_r <= !w_op[0] && w_a[31];
        r_dz <= w_b == 32'd0;
        r_acc <= {32'd0, w_op[1] ? w_am : w_bm};
        r_b <= w_op[1] ? w_bm : w_am;
      end else if (r_state == BUSY) r_acc <= w_acc_step;
      if (w_done) begin
        r_hi <= r_div ? (r_neg_r ? -w_r : w_r) : w_prod[63:32];
        r_lo <= r_div ? (r_dz ? 32'hFFFF_FFFF : r_neg_q ? -w_q : w_q) : w_prod[31:0];
      end
      r_wb <= (w_bubble || w_ovf) ? 2'd0 : bus.i_wb;
      r_m <= w_bubble ? 3'd0 : bus.i_m;
      r_alu <= w_bubble ? 32'd0 : w_res;
      r_store <= w_bubble ? 32'd0 : bus.i_reg_rt;
      r_dest <= (w_bubble || bus.i_ex[8]) ? 5'd0 : bus.i_ex[9] ? bus.i_addr_rd : bus.i_addr_rt;
      r_ovf <= !w_bubble && w_ovf;
    end
  end
  assign bus.o_stall = w_stall && rst_n;
  assign bus.o_wb = r_wb;
  assign bus.o_m = r_m;
  assign bus.o_alu_result = r_alu;
  assign bus.o_store_data = r_store;
  assign bus.o_dest_addr = r_dest;
  assign bus.o_overflow = r_ovf;
endmodule
